apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

APB3 completer (slave) that answers the transfers driven on the `apb_intf` bus: a word-addressed memory with a fixed, parameterised number of wait states and error signalling on bad addresses. It sits on the responder side of the bus, opposite the UVM driver that acts as requester. The bus monitor and its assertions observe it unchanged.

## Interface
- `MEM_DEPTH`, 64: number of 32-bit words; legal byte addresses are 0 .. 4*MEM_DEPTH-4.
- `WAIT_STATES`, 0: access-phase cycles with PREADY low before completion; range 0..15.

- `PCLK`  in  1: bus clock; all logic is on the rising edge.
- `PRESETn`  in  1: reset, synchronous, active-low.
- `PSELx`  in  1: slave select.
- `PENABLE`  in  1: access-phase indicator.
- `PWRITE`  in  1: 1 = write, 0 = read.
- `PADDR`  in  32: byte address.
- `PWDATA`  in  32: write data.
- `PRDATA`  out  32: read data.
- `PREADY`  out  1: transfer completes in this cycle.
- `PSLVERR`  out  1: transfer error, valid only while PREADY=1.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS on an edge with PSELx=1, PENABLE=0 (setup phase).
  - ACCESS → IDLE on the completion edge.
  - ACCESS → IDLE on abort.
- Setup edge actions:
  - Latch PADDR into addr_q and PWRITE into wr_q.
  - Load wait_cnt ← WAIT_STATES (4-bit).
  - Compute err_q = (PADDR[1:0] != 0) OR (PADDR[31:2] >= MEM_DEPTH).
  - For a read: PRDATA ← err_q ? 0 : mem[PADDR[31:2]].
  - For a write: PRDATA holds its value.
- ACCESS, wait_cnt != 0, PSELx=1, PENABLE=1: decrement wait_cnt on each edge.
- PREADY = (state==ACCESS) && (wait_cnt==0). PREADY is combinational from registered state.
- PSLVERR = PREADY && err_q. It is 0 in every other cycle.
- Completion edge (PREADY=1, PSELx=1, PENABLE=1):
  - Write with !err_q: mem[addr_q] ← PWDATA, sampled on this edge.
  - Write with err_q: memory unchanged.
  - Read: no side effect; PRDATA stays valid through the completion cycle and holds afterwards.
- Abort: in ACCESS, PSELx=0 or PENABLE=0 before completion → IDLE with no memory write and no PREADY.
- Address and direction used are the latched ones. PADDR/PWRITE changes during ACCESS are ignored.
- PRDATA changes only at a read setup edge or at reset.
- Reset (PRESETn=0 on an edge, including mid-transfer):
  - State → IDLE, wait_cnt=0, PRDATA=0.
  - PREADY=0 and PSLVERR=0 from the next cycle.
  - All MEM_DEPTH words cleared to 0.
  - While PRESETn=0, setup phases are ignored.

## Timing
- Cycle numbering:
  - Setup cycle S: sampled at edge E0.
  - First access cycle A1 follows E0.
  - PREADY rises in cycle A(1+WAIT_STATES).
  - Completion at the end of that cycle.
- Transfer length = 2 + WAIT_STATES cycles; WAIT_STATES=0 gives the minimum two-cycle APB transfer.
- Read data is visible from A1, i.e. one cycle after the setup edge, and held through completion.
- Write data is committed on the completion edge and is readable by a following transfer whose setup cycle is the next cycle.
- Back-to-back transfers:
  - After completion the FSM is in IDLE.
  - A setup cycle immediately following is accepted; there are no lost cycles.
- Simultaneous reset and completion edge: reset wins and the write is not committed.
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0.

## Test plan
- Reset: hold PRESETn=0 for 3 edges after writing 0xDEADBEEF to 0x10 → PRDATA=0, PREADY=0, PSLVERR=0. A subsequent read of 0x10 returns 0.
- Write then read, WAIT_STATES=0: write 0xA5A5_1234 to 0x08, then immediately read 0x08.
  - PREADY is high in each transfer's second cycle.
  - PRDATA = 0xA5A5_1234, PSLVERR=0.
- Wait states, WAIT_STATES=3: read 0x00 → PREADY low for 3 access cycles, high in the 4th; total 5 cycles.
- Errors, MEM_DEPTH=64: each of the following gives PSLVERR=1 in its completion cycle.
  - Write 0x1111_1111 to 0x100 (out of range): memory unchanged.
  - Write to 0x06 (misaligned): word 0x04 unchanged.
  - Read 0x100: PRDATA=0.
- Abort: WAIT_STATES=2, write 0x5555_5555 to 0x20, drop PSELx in A2 → no PREADY. A subsequent read of 0x20 returns its old value.
- Reset mid-transfer: PRESETn=0 in A1 of a write with WAIT_STATES=1 → PREADY never asserts, the FSM returns to IDLE, and a following write/read pair to 0x0C works normally.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory.
// It inserts a fixed number of wait states and raises PSLVERR on misaligned or out-of-range addresses.
module apb_slave_mem #(
   parameter int MEM_DEPTH   = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSELx,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        dbg_state_o
);

   localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q;
   logic          wr_q;
   logic          err_q;
   logic [3:0]    wait_cnt_q;
   logic [31:0]   prdata_q;
   logic [31:0]   mem_q [MEM_DEPTH];

   logic          setup_hit;
   logic          xfer_on;
   logic          complete;
   logic          setup_err;
   logic [AW-1:0] setup_idx;

   // Handshake: a transfer starts with PSELx=1, PENABLE=0 seen in IDLE.
   // It completes on the edge where PREADY, PSELx and PENABLE are all high.
   // Losing PSELx or PENABLE before that edge aborts the transfer.
   assign setup_hit = (state_q == IDLE) && PSELx && !PENABLE;
   assign xfer_on   = PSELx && PENABLE;
   assign setup_err = (PADDR[1:0] != 2'b00) || ({2'b00, PADDR[31:2]} >= DEPTH_W);
   assign setup_idx = PADDR[AW+1:2];

   assign PREADY      = (state_q == ACCESS) && (wait_cnt_q == 4'd0);
   assign PSLVERR     = PREADY && err_q;
   assign complete    = PREADY && xfer_on;
   assign PRDATA      = prdata_q;
   assign dbg_state_o = (state_q == ACCESS);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (setup_hit) state_d = ACCESS;
         ACCESS:  if (!xfer_on || PREADY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         addr_q     <= '0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         wait_cnt_q <= 4'd0;
         prdata_q   <= '0;
      end else if (setup_hit) begin
         addr_q     <= setup_idx;
         wr_q       <= PWRITE;
         err_q      <= setup_err;
         wait_cnt_q <= 4'(WAIT_STATES);
         // Read data is fetched at setup so it is already valid in the first access cycle.
         if (!PWRITE) prdata_q <= setup_err ? 32'h0 : mem_q[setup_idx];
      end else if ((state_q == ACCESS) && (wait_cnt_q != 4'd0) && xfer_on) begin
         wait_cnt_q <= wait_cnt_q - 4'd1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else if (complete && wr_q && !err_q) begin
         mem_q[addr_q] <= PWDATA;
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: four instances with 0..3 wait states share one bus, each with its own PSELx.
// Directed scenarios run first, then randomized transfers checked against an array model of each memory.
module tb_apb_slave_mem;

   localparam int MEM_DEPTH = 64;
   localparam int NDUT      = 4;

   logic              pclk;
   logic              presetn;
   logic [NDUT-1:0]   psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       paddr;
   logic [31:0]       pwdata;
   logic [31:0]       prdata [NDUT];
   logic [NDUT-1:0]   pready;
   logic [NDUT-1:0]   pslverr;
   logic [NDUT-1:0]   dbg_state;

   logic [31:0]       ref_mem [NDUT][MEM_DEPTH];
   logic [31:0]       ref_prdata [NDUT];
   logic [31:0]       exp_q [$];

   int n_checks = 0;
   int n_errors = 0;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      apb_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(k)) u_dut (
         .PCLK        (pclk),
         .PRESETn     (presetn),
         .PSELx       (psel[k]),
         .PENABLE     (penable),
         .PWRITE      (pwrite),
         .PADDR       (paddr),
         .PWDATA      (pwdata),
         .PRDATA      (prdata[k]),
         .PREADY      (pready[k]),
         .PSLVERR     (pslverr[k]),
         .dbg_state_o (dbg_state[k])
      );
   end

   // clock and watchdog
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic bit addr_err(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || ((addr >> 2) >= MEM_DEPTH);
   endfunction

   task automatic model_clear();
      for (int d = 0; d < NDUT; d++) begin
         ref_prdata[d] = '0;
         for (int w = 0; w < MEM_DEPTH; w++) ref_mem[d][w] = '0;
      end
   endtask

   // All driver tasks start and end right at a rising edge.
   task automatic idle(input int n);
      #1;
      psel    = '0;
      penable = 1'b0;
      repeat (n) @(posedge pclk);
   endtask

   task automatic do_reset(input int n, input bit junk_setup);
      #1;
      presetn = 1'b0;
      psel    = '0;
      penable = 1'b0;
      if (junk_setup) begin
         psel[0] = 1'b1;
         pwrite  = 1'b0;
         paddr   = 32'h10;
      end
      repeat (n) @(posedge pclk);
      #1;
      psel    = '0;
      presetn = 1'b1;
      model_clear();
      @(posedge pclk);
   endtask

   task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
      bit          exp_err;
      bit          done;
      int          n;
      logic [31:0] exp_rd;
      exp_err = addr_err(addr);
      if (!wr) begin
         exp_rd = exp_err ? 32'h0 : ref_mem[d][addr[31:2]];
         exp_q.push_back(exp_rd);
         ref_prdata[d] = exp_rd;
      end
      #1;
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      paddr   = $urandom;
      pwrite  = ~wr;
      done    = 1'b0;
      n       = 0;
      while (!done && n < 20) begin
         n++;
         @(negedge pclk);
         check_eq("prdata_hold", prdata[d], ref_prdata[d]);
         if (pready[d]) begin
            done = 1'b1;
            check_eq("pslverr", {31'b0, pslverr[d]}, {31'b0, exp_err});
            if (!wr) begin
               exp_rd = exp_q.pop_front();
               check_eq("rdata", prdata[d], exp_rd);
            end
         end else begin
            check_eq("pslverr_low", {31'b0, pslverr[d]}, 32'h0);
         end
         @(posedge pclk);
      end
      check_eq("latency", 32'(n), 32'(d + 1));
      if (!done) begin
         check_eq("timeout", 32'h0, 32'h1);
         if (!wr) void'(exp_q.pop_back());
         idle(1);
      end
      if (wr && !exp_err) ref_mem[d][addr[31:2]] = wdata;
   endtask

   // PSELx and PENABLE fall at the start of access cycle drop_at, which must be in 1..d.
   task automatic apb_abort(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input int drop_at);
      if (!wr) ref_prdata[d] = addr_err(addr) ? 32'h0 : ref_mem[d][addr[31:2]];
      #1;
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      for (int n = 1; n <= drop_at; n++) begin
         if (n == drop_at) begin
            psel    = '0;
            penable = 1'b0;
         end
         @(negedge pclk);
         check_eq("abort_no_ready", {31'b0, pready[d]}, 32'h0);
         @(posedge pclk);
         if (n < drop_at) #1;
      end
      @(negedge pclk);
      check_eq("abort_idle", {31'b0, dbg_state[d]}, 32'h0);
      check_eq("abort_ready_low", {31'b0, pready[d]}, 32'h0);
      check_eq("abort_prdata", prdata[d], ref_prdata[d]);
      @(posedge pclk);
   endtask

   initial begin
      int          d;
      int          sel;
      bit          wr;
      logic [31:0] addr;

      presetn = 1'b0;
      psel    = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      @(posedge pclk);
      do_reset(2, 1'b0);
      @(negedge pclk);
      for (int k = 0; k < NDUT; k++) begin
         check_eq("rst_prdata", prdata[k], 32'h0);
         check_eq("rst_pready", {31'b0, pready[k]}, 32'h0);
         check_eq("rst_pslverr", {31'b0, pslverr[k]}, 32'h0);
      end
      @(posedge pclk);

      // reset clears memory and PRDATA; setups driven during reset are ignored
      apb_xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      apb_xfer(0, 1'b0, 32'h10, 32'h0);
      do_reset(3, 1'b1);
      @(negedge pclk);
      check_eq("rst2_prdata", prdata[0], 32'h0);
      check_eq("rst2_pready", {31'b0, pready[0]}, 32'h0);
      check_eq("rst2_pslverr", {31'b0, pslverr[0]}, 32'h0);
      check_eq("rst2_idle", {31'b0, dbg_state[0]}, 32'h0);
      @(posedge pclk);
      apb_xfer(0, 1'b0, 32'h10, 32'h0);

      // back-to-back write then read, zero wait states
      apb_xfer(0, 1'b1, 32'h08, 32'hA5A5_1234);
      apb_xfer(0, 1'b0, 32'h08, 32'h0);

      // three wait states
      apb_xfer(3, 1'b1, 32'h00, 32'h0BAD_CAFE);
      apb_xfer(3, 1'b0, 32'h00, 32'h0);

      // error responses leave memory untouched
      apb_xfer(0, 1'b1, 32'h04, 32'hCAFE_F00D);
      apb_xfer(0, 1'b1, 32'h100, 32'h1111_1111);
      apb_xfer(0, 1'b0, 32'h00, 32'h0);
      apb_xfer(0, 1'b1, 32'h06, 32'h1234_5678);
      apb_xfer(0, 1'b0, 32'h04, 32'h0);
      apb_xfer(0, 1'b0, 32'h100, 32'h0);

      // abort in the second access cycle with two wait states
      apb_xfer(2, 1'b1, 32'h20, 32'h0000_0077);
      apb_abort(2, 1'b1, 32'h20, 32'h5555_5555, 2);
      apb_xfer(2, 1'b0, 32'h20, 32'h0);

      // reset asserted in the first access cycle of a one-wait-state write
      #1;
      psel    = '0;
      psel[1] = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h0C;
      pwdata  = 32'h1357_9BDF;
      @(posedge pclk);
      #1;
      penable = 1'b1;
      presetn = 1'b0;
      @(negedge pclk);
      check_eq("midrst_ready_a1", {31'b0, pready[1]}, 32'h0);
      @(posedge pclk);
      #1;
      psel    = '0;
      penable = 1'b0;
      @(negedge pclk);
      check_eq("midrst_ready", {31'b0, pready[1]}, 32'h0);
      check_eq("midrst_idle", {31'b0, dbg_state[1]}, 32'h0);
      @(posedge pclk);
      #1;
      presetn = 1'b1;
      model_clear();
      @(posedge pclk);
      apb_xfer(1, 1'b0, 32'h0C, 32'h0);
      apb_xfer(1, 1'b1, 32'h0C, 32'h2468_ACE0);
      apb_xfer(1, 1'b0, 32'h0C, 32'h0);

      // randomized traffic across all instances
      for (int t = 0; t < 300; t++) begin
         d   = $urandom_range(0, NDUT - 1);
         wr  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         if (sel <= 6)      addr = {24'h0, 6'($urandom_range(0, MEM_DEPTH - 1)), 2'b00};
         else if (sel == 7) addr = {24'h0, 6'($urandom_range(0, MEM_DEPTH - 1)), 2'($urandom_range(1, 3))};
         else if (sel == 8) addr = 32'(MEM_DEPTH + $urandom_range(0, 200)) << 2;
         else               addr = $urandom;
         if (d >= 1 && $urandom_range(0, 7) == 0)
            apb_abort(d, wr, addr, $urandom, $urandom_range(1, d));
         else
            apb_xfer(d, wr, addr, $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end

      check_eq("exp_q_empty", 32'(exp_q.size()), 32'h0);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
